// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the execute hazard controller.
// Holds fwd encodings, FSM states and the scoreboard entry layout.
package hazard_pkg;

  localparam int SB_REG_W = 8;

  typedef logic [1:0] fwd_t;

  localparam fwd_t FWD_RF    = 2'b00;
  localparam fwd_t FWD_EXMEM = 2'b01;
  localparam fwd_t FWD_MEMWB = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEMWAIT,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  typedef struct packed {
    logic                valid;
    logic                wr_en;
    logic [SB_REG_W-1:0] wr_reg;
    logic                is_load;
    logic                is_halt;
  } sb_entry_t;

  function automatic logic hit(
    input sb_entry_t           e,
    input logic                used,
    input logic [SB_REG_W-1:0] src
  );
    return used && e.valid && e.wr_en &&
           (e.wr_reg == src);
  endfunction

  function automatic fwd_t fwd_sel(
    input sb_entry_t           ex,
    input sb_entry_t           mem,
    input logic                used,
    input logic [SB_REG_W-1:0] src
  );
    if (hit(ex, used, src))
      return FWD_EXMEM;
    if (hit(mem, used, src))
      return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/sb_entry.sv
// sb_entry: one scoreboard stage register (async reset, hold, clear).
// Ports: clk, rst_n, hold, clear, d (next entry), q (current entry).
module sb_entry
  import hazard_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      hold,
  input  logic      clear,
  input  sb_entry_t d,
  output sb_entry_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (!hold)
      q <= clear ? '0 : d;
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: hazard tracking, forwarding, stall/flush and halt.
// Ports: decode info in, redirect/mem_stall in; stall/bubble/flush/fwd/halted out.
module ex_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic             id_is_load,
  input  logic             id_is_halt,
  input  logic             ex_redirect,
  input  logic             mem_stall,
  output logic             stall_if_id,
  output logic             bubble_ex,
  output logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted
);

  state_t    state, state_n;
  state_t    ret, ret_n, eff;
  sb_entry_t id_e, ex_q, mem_q, wb_q;
  logic      lu, install, wb_halt;
  logic      unused_wb;
  fwd_t      fa_n, fb_n;
  logic [SB_REG_W-1:0] rs, rt;

  assign rs = SB_REG_W'(id_rs);
  assign rt = SB_REG_W'(id_rt);

  // While frozen, the state to resume lives in ret.
  assign eff = (state == ST_MEMWAIT) ? ret : state;

  assign wb_halt = wb_q.valid && wb_q.is_halt;

  assign lu = id_valid && (eff == ST_RUN) &&
              ex_q.valid && ex_q.is_load &&
              ((id_uses_rs && ex_q.wr_reg == rs) ||
               (id_uses_rt && ex_q.wr_reg == rt));

  assign install = id_valid && (eff == ST_RUN) &&
                   !ex_redirect && !lu;

  assign id_e = '{
    valid:   1'b1,
    wr_en:   id_wr_en,
    wr_reg:  SB_REG_W'(id_wr_reg),
    is_load: id_is_load,
    is_halt: id_is_halt
  };

  assign fa_n = fwd_sel(ex_q, mem_q, id_uses_rs, rs);
  assign fb_n = fwd_sel(ex_q, mem_q, id_uses_rt, rt);

  sb_entry u_ex (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (mem_stall),
    .clear (!install),
    .d     (id_e),
    .q     (ex_q)
  );

  sb_entry u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (mem_stall),
    .clear (1'b0),
    .d     (ex_q),
    .q     (mem_q)
  );

  sb_entry u_wb (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (mem_stall),
    .clear (1'b0),
    .d     (mem_q),
    .q     (wb_q)
  );

  assign unused_wb = ^{wb_q.wr_en, wb_q.wr_reg,
                       wb_q.is_load};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      ret   <= ST_RUN;
    end else begin
      state <= state_n;
      ret   <= ret_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end else if (!mem_stall) begin
      fwd_a <= install ? fa_n : FWD_RF;
      fwd_b <= install ? fb_n : FWD_RF;
    end
  end

  always_comb begin
    state_n = state;
    ret_n   = ret;
    if (state != ST_HALTED) begin
      if (mem_stall) begin
        state_n = ST_MEMWAIT;
        ret_n   = eff;
      end else begin
        state_n = eff;
        if (eff == ST_RUN && install && id_is_halt)
          state_n = ST_DRAIN;
        if (eff == ST_DRAIN && wb_halt)
          state_n = ST_HALTED;
      end
    end
  end

  // halted rises while the HALT entry is retiring out of WB.
  always_comb begin
    stall_if_id = 1'b0;
    bubble_ex   = 1'b0;
    flush       = 1'b0;
    halted      = (eff == ST_HALTED) || wb_halt;
    if (mem_stall) begin
      stall_if_id = 1'b1;
    end else if (eff == ST_HALTED) begin
      stall_if_id = 1'b1;
    end else if (eff == ST_DRAIN) begin
      stall_if_id = 1'b1;
      flush       = ex_redirect;
    end else if (ex_redirect) begin
      flush = 1'b1;
    end else if (lu) begin
      stall_if_id = 1'b1;
      bubble_ex   = 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl: directed bench for ex_hazard_ctrl.
// Expected outputs go through a queue and are checked each cycle.
module tb_ex_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid;
  logic [2:0] id_rs, id_rt;
  logic       id_uses_rs, id_uses_rt;
  logic       id_wr_en;
  logic [2:0] id_wr_reg;
  logic       id_is_load, id_is_halt;
  logic       ex_redirect, mem_stall;
  logic       stall_if_id, bubble_ex, flush;
  logic [1:0] fwd_a, fwd_b;
  logic       halted;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] obs;

  assign obs = {stall_if_id, bubble_ex, flush,
                fwd_a, fwd_b, halted};

  always #5 clk = ~clk;

  ex_hazard_ctrl #(.REG_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .id_wr_en    (id_wr_en),
    .id_wr_reg   (id_wr_reg),
    .id_is_load  (id_is_load),
    .id_is_halt  (id_is_halt),
    .ex_redirect (ex_redirect),
    .mem_stall   (mem_stall),
    .stall_if_id (stall_if_id),
    .bubble_ex   (bubble_ex),
    .flush       (flush),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .halted      (halted)
  );

  task automatic idle();
    id_valid   = 1'b0;
    id_rs      = 3'd0;
    id_rt      = 3'd0;
    id_uses_rs = 1'b0;
    id_uses_rt = 1'b0;
    id_wr_en   = 1'b0;
    id_wr_reg  = 3'd0;
    id_is_load = 1'b0;
    id_is_halt = 1'b0;
  endtask

  task automatic ins(
    input logic [2:0] rs, input logic [2:0] rt,
    input logic urs, input logic urt,
    input logic wr, input logic [2:0] wreg,
    input logic ld, input logic hlt
  );
    id_valid   = 1'b1;
    id_rs      = rs;
    id_rt      = rt;
    id_uses_rs = urs;
    id_uses_rt = urt;
    id_wr_en   = wr;
    id_wr_reg  = wreg;
    id_is_load = ld;
    id_is_halt = hlt;
  endtask

  task automatic compare();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %b expected %b",
               e.tag, obs, e.val);
      end
    end
  endtask

  // Push expectation, sample 1ns later, move to next negedge.
  task automatic step(
    input string tag,
    input logic s, input logic b, input logic f,
    input logic [1:0] fa, input logic [1:0] fb,
    input logic h
  );
    exp_t e;
    e.tag = tag;
    e.val = {s, b, f, fa, fb, h};
    exp_q.push_back(e);
    #1;
    compare();
    @(negedge clk);
  endtask

  initial begin
    idle();
    ex_redirect = 1'b0;
    mem_stall   = 1'b0;
    @(negedge clk);
    step("reset", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    rst_n = 1'b1;

    // forwarding 01 then 10
    ins(3'd4, 3'd5, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
    step("add_r1", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    ins(3'd1, 3'd6, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0);
    step("sub_dec", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    ins(3'd2, 3'd1, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
    step("fwd_exmem_a", 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);
    idle();
    step("fwd_memwb_b", 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0);
    step("fwd_clear", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

    // EX beats MEM for same register
    ins(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    step("pri_a", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("pri_b", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    ins(3'd3, 3'd3, 1'b1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0);
    step("pri_dec", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    idle();
    step("pri_ex", 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0);

    // load-use
    ins(3'd5, 3'd5, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
    step("ld_dec", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    ins(3'd6, 3'd2, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
    step("lu_stall", 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    step("lu_release", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    idle();
    step("lu_fwd_b", 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0);
    step("lu_clear", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

    // redirect beats load-use, instr not installed
    ins(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0);
    step("ld2_dec", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    ins(3'd1, 3'd0, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0);
    ex_redirect = 1'b1;
    step("redir", 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
    ex_redirect = 1'b0;
    ins(3'd6, 3'd1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    step("redir_next", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    idle();
    step("redir_noinst", 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0);
    step("redir_clear", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

    // mem_stall freeze for 3 cycles
    ins(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    step("ms_add", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    ins(3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
    step("ms_use", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    ins(3'd4, 3'd3, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
    mem_stall = 1'b1;
    step("ms1", 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);
    step("ms2", 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);
    step("ms3", 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);
    mem_stall = 1'b0;
    step("ms_resume", 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);
    idle();
    step("ms_fwd", 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0);
    step("ms_clear", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("ms_idle", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

    // halt sequence
    ins(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    step("halt_dec", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    ins(3'd1, 3'd0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    step("drain1", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("drain2", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    step("halt_rise", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    idle();
    step("halt_hold", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    rst_n = 1'b0;
    step("rst_halted", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    rst_n = 1'b1;

    // reset out of MEMWAIT
    mem_stall = 1'b1;
    step("memwait", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    mem_stall = 1'b0;
    rst_n = 1'b0;
    step("rst_memwait", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    rst_n = 1'b1;
    ins(3'd4, 3'd5, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
    step("post_add", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    ins(3'd1, 3'd0, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0);
    step("post_use", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    idle();
    step("post_fwd", 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_hazard_ctrl.md
# ex_hazard_ctrl

Pipeline hazard controller for the five-stage processor. It tracks in-flight destination registers behind the decode stage and drives the execute-stage operand forwarding selects. It also generates stall, bubble and flush controls for load-use hazards, taken branches/jumps resolved in execute, and data-memory wait states. It sequences processor halt: fetch stops, the pipe drains, and the halted state is held.

## Interface

Parameters:
- REG_W, 3, register-index width (8 GPRs; R0 is an ordinary register)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  real instruction in decode
- id_rs, id_rt  in  REG_W  source register indices of decode instruction
- id_uses_rs, id_uses_rt  in  1  source actually read
- id_wr_en  in  1  decode instruction writes the register file
- id_wr_reg  in  REG_W  destination index
- id_is_load  in  1  decode instruction is a load
- id_is_halt  in  1  decode instruction is HALT
- ex_redirect  in  1  execute resolved a taken branch/jump this cycle
- mem_stall  in  1  data memory not ready; freeze the whole pipe
- stall_if_id  out  1  hold PC and IF/ID register
- bubble_ex  out  1  load NOP into ID/EX
- flush  out  1  squash IF/ID and ID/EX contents
- fwd_a, fwd_b  out  2  execute operand select: 00 regfile, 01 EX/MEM result, 10 MEM/WB writeback data
- halted  out  1  processor halted (sticky)

## Operation

- Scoreboard: three entries (EX, MEM, WB), each {valid, wr_en, wr_reg, is_load, is_halt}. Each advancing cycle it shifts EX→MEM→WB. The decode instruction enters EX unless bubbled or flushed, which enters an invalid entry.
- Forwarding is computed in decode against the EX and MEM entries, whose contents will be in EX/MEM and MEM/WB when the instruction executes. It is registered into fwd_a/fwd_b with the instruction. The EX entry match has priority (01) over the MEM entry match (10). The WB entry needs no forward because the regfile writes before it reads. Only valid, wr_en entries match.
- Load-use: if the EX entry is a valid load and its wr_reg equals a used source, then stall_if_id=1 and bubble_ex=1 for exactly one cycle. The load then sits in MEM and is forwarded via 10.
- Redirect: flush=ex_redirect, combinational. The decode instruction is not installed. Redirect beats load-use, so no stall that cycle. Entries already in MEM/WB are unaffected.
- FSM states:
  - RUN: normal operation.
  - MEMWAIT: entered while mem_stall=1. stall_if_id=1, bubble_ex=0, flush=0. Scoreboard and fwd outputs hold. Returns to the prior state when mem_stall drops.
  - DRAIN: entered when a valid id_is_halt is installed. stall_if_id=1 from the next cycle. Later decode inputs are ignored.
  - HALTED: entered when the halt entry retires out of WB. halted=1 and stall_if_id=1 until reset.
- mem_stall has priority over redirect and load-use. A redirect coinciding with mem_stall is acted on in the first non-stalled cycle, because ex_redirect is held by the frozen pipe.

## Timing

- Reset (asynchronous, rst_n=0): state RUN, all scoreboard entries invalid, fwd_a=fwd_b=00, stall_if_id=bubble_ex=flush=halted=0.
- fwd_* are registered, one-cycle latency from decode to execute.
- stall_if_id, bubble_ex and flush are combinational from inputs and state.
- A load-use stall lasts 1 cycle, or longer only if mem_stall overlaps.
- The halted rise occurs 3 advancing cycles after HALT leaves decode.
- Reset asserted mid-DRAIN or mid-MEMWAIT returns to RUN immediately.

## Structure

- A shared package (hazard_pkg) holds:
  - the fwd encodings FWD_RF/FWD_EXMEM/FWD_MEMWB
  - the FSM state encoding
  - the scoreboard-entry field layout
- One sub-module, sb_entry: one flop-based scoreboard stage with async reset, hold and clear inputs. It is instantiated three times.
- The FSM, match compare and priority logic live in the top module.

## Test plan

- ADD R1 in ID, next SUB uses R1 as rs → next cycle fwd_a=01; the cycle after, if the consumer is two behind, fwd_a=10.
- LD R2, then ADD uses R2 as rt → stall_if_id=1 and bubble_ex=1 for exactly one cycle, then fwd_b=10.
- ex_redirect=1 while a load-use condition is present in ID → flush=1, bubble/stall=0, the decode instruction is never installed (no later forward to its wr_reg).
- mem_stall high for 3 cycles with a forward pending → stall_if_id=1, fwd_a/fwd_b and scoreboard unchanged for all 3 cycles, resuming exactly where they left off.
- HALT installed at cycle N with no stalls → stall_if_id=1 from N+1, halted=1 at N+3 and stays 1; rst_n low clears all outputs to 0 asynchronously.
- Both sources equal to the EX and MEM destinations (R3 in both) → EX priority, fwd=01.
